// File: rtl/hdmi_fb_pkg.sv
// Shared definitions for the HDMI framebuffer streamer: output mode encodings,
// the colour-bar table, the per-pixel delay-line tag and width helpers.
package hdmi_fb_pkg;

    typedef enum logic [1:0] {
        MODE_FB    = 2'b00,
        MODE_BARS  = 2'b01,
        MODE_FILL  = 2'b10,
        MODE_BLACK = 2'b11
    } mode_e;

    localparam int NUM_BARS = 8;

    // Index 0 is the leftmost bar; each entry is {ch2,ch1,ch0} at full scale or zero.
    localparam logic [NUM_BARS-1:0][2:0] BAR_TABLE = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       act;
        logic [2:0] bar;
        mode_e      mode;
    } vid_tag_t;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

    function automatic int cnt_width(input int total);
        return (clog2(total) < 1) ? 1 : clog2(total);
    endfunction

endpackage

// File: rtl/hdmi_timing_gen.sv
// Horizontal/vertical raster counters with raw sync, active-area decode and the
// frame-start / frame-sync strobes, all decoded straight from the counters.
module hdmi_timing_gen
    import hdmi_fb_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_hs_raw,
    output logic o_vs_raw,
    output logic o_act,
    output logic o_frame_start,
    output logic o_frame_sync
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HW      = cnt_width(H_TOTAL);
    localparam int VW      = cnt_width(V_TOTAL);

    localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_END  = HW'(H_SYNC);
    localparam logic [VW-1:0] V_SYNC_END  = VW'(V_SYNC);
    localparam logic [HW-1:0] H_ACT_FIRST = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] H_ACT_LAST  = HW'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [VW-1:0] V_ACT_FIRST = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] V_ACT_LAST  = VW'(V_SYNC + V_BP + V_ACTIVE - 1);
    // With no vertical front porch the swap point coincides with line 0.
    localparam logic [VW-1:0] V_FS_LINE   = VW'((V_SYNC + V_BP + V_ACTIVE) % V_TOTAL);

    logic [HW-1:0] r_hcount;
    logic [VW-1:0] r_vcount;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (r_hcount == H_LAST) begin
            r_hcount <= '0;
            r_vcount <= (r_vcount == V_LAST) ? '0 : r_vcount + 1'b1;
        end else begin
            r_hcount <= r_hcount + 1'b1;
        end
    end

    assign o_hs_raw      = (r_hcount < H_SYNC_END);
    assign o_vs_raw      = (r_vcount < V_SYNC_END);
    assign o_act         = (r_hcount >= H_ACT_FIRST) && (r_hcount <= H_ACT_LAST) &&
                           (r_vcount >= V_ACT_FIRST) && (r_vcount <= V_ACT_LAST);
    assign o_frame_start = (r_hcount == '0) && (r_vcount == '0);
    assign o_frame_sync  = (r_hcount == '0) && (r_vcount == V_FS_LINE);

endmodule

// File: rtl/hdmi_fb_stream.sv
// Framebuffer-to-TMDS pixel streamer: address generation, frame-latched mode,
// a delay line matching the RAM read latency, and the registered pixel mux.
module hdmi_fb_stream
    import hdmi_fb_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int RD_LAT   = 1,
    parameter int BPC      = 8,
    parameter int DIN_W    = 32,
    parameter int ADDR_W   = 19
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [1:0]        i_mode,
    input  logic [3*BPC-1:0]  i_fill_color,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DIN_W-1:0]  i_din,
    output logic [BPC-1:0]    o_ch0,
    output logic [BPC-1:0]    o_ch1,
    output logic [BPC-1:0]    o_ch2,
    output logic              o_hsync,
    output logic              o_vsync,
    output logic              o_data_en,
    output logic              o_frame_sync,
    output logic              o_hdmi_enable
);

    localparam int BAR_W = H_ACTIVE / NUM_BARS;
    localparam int BW    = cnt_width(BAR_W);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    if (ADDR_W < clog2(H_ACTIVE * V_ACTIVE)) begin : g_addr_w_check
        $error("hdmi_fb_stream: ADDR_W too small for H_ACTIVE*V_ACTIVE");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_rd_lat_check
        $error("hdmi_fb_stream: RD_LAT must be 1..4");
    end
    if (DIN_W < 3 * BPC) begin : g_din_w_check
        $error("hdmi_fb_stream: DIN_W must hold three channels");
    end
    if ((H_ACTIVE % NUM_BARS) != 0) begin : g_h_active_check
        $error("hdmi_fb_stream: H_ACTIVE must be a multiple of 8");
    end

    logic w_hs_raw;
    logic w_vs_raw;
    logic w_act;
    logic w_frame_start;
    logic w_frame_sync;

    hdmi_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .o_hs_raw      (w_hs_raw),
        .o_vs_raw      (w_vs_raw),
        .o_act         (w_act),
        .o_frame_start (w_frame_start),
        .o_frame_sync  (w_frame_sync)
    );

    mode_e             r_mode;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [BW-1:0]     r_bar_cnt;
    logic [2:0]        r_bar_idx;

    // Mode only changes at the top of a frame so a frame never mixes sources.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode <= MODE_BLACK;
        end else if (w_frame_start) begin
            r_mode <= mode_e'(i_mode);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
        end else begin
            r_rd_en <= w_act && (r_mode == MODE_FB);
            if (w_frame_start) begin
                r_rd_addr <= '0;
            end else if (r_rd_en) begin
                r_rd_addr <= r_rd_addr + 1'b1;
            end
        end
    end

    // Bar index tracks the stage-0 counters so it stays aligned with act.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bar_cnt <= '0;
            r_bar_idx <= '0;
        end else if (!w_act) begin
            r_bar_cnt <= '0;
            r_bar_idx <= '0;
        end else if (r_bar_cnt == BAR_LAST) begin
            r_bar_cnt <= '0;
            r_bar_idx <= r_bar_idx + 3'd1;
        end else begin
            r_bar_cnt <= r_bar_cnt + 1'b1;
        end
    end

    vid_tag_t w_tag;
    vid_tag_t r_dly [RD_LAT+1];
    vid_tag_t w_last;

    assign w_tag  = {w_hs_raw, w_vs_raw, w_act, r_bar_idx, r_mode};
    assign w_last = r_dly[RD_LAT];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i <= RD_LAT; i++) begin
                r_dly[i] <= '0;
            end
        end else begin
            r_dly[0] <= w_tag;
            for (int i = 1; i <= RD_LAT; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    logic [3*BPC-1:0] w_pix;
    logic [2:0]       w_bar_bits;

    always_comb begin
        w_pix      = '0;
        w_bar_bits = BAR_TABLE[w_last.bar];
        if (w_last.act) begin
            case (w_last.mode)
                MODE_FB:   w_pix = i_din[3*BPC-1:0];
                MODE_BARS: w_pix = {{BPC{w_bar_bits[2]}}, {BPC{w_bar_bits[1]}}, {BPC{w_bar_bits[0]}}};
                MODE_FILL: w_pix = i_fill_color;
                default:   w_pix = '0;
            endcase
        end
    end

    logic [3*BPC-1:0] r_pix;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_data_en;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pix     <= '0;
            r_hsync   <= ~SYNC_POL;
            r_vsync   <= ~SYNC_POL;
            r_data_en <= 1'b0;
        end else begin
            r_pix     <= w_pix;
            r_hsync   <= w_last.hs ? SYNC_POL : ~SYNC_POL;
            r_vsync   <= w_last.vs ? SYNC_POL : ~SYNC_POL;
            r_data_en <= w_last.act;
        end
    end

    logic w_unused_din;
    assign w_unused_din = ^i_din;

    assign o_rd_en       = r_rd_en;
    assign o_rd_addr     = r_rd_addr;
    assign o_ch0         = r_pix[BPC-1:0];
    assign o_ch1         = r_pix[2*BPC-1:BPC];
    assign o_ch2         = r_pix[3*BPC-1:2*BPC];
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_data_en     = r_data_en;
    assign o_frame_sync  = w_frame_sync;
    assign o_hdmi_enable = 1'b1;

endmodule
